// File: rtl/combined_counter_ctrl.sv
// combined_counter_ctrl: command-driven sequencer for a WIDTH-bit Johnson/ring
// shift counter. A command (mode, optional seed, step count) is accepted over a
// valid/ready handshake. The block then shifts the pattern exactly N times. It
// reports wrap-around of the start pattern and completion, and a run can be
// aborted.
//
// Handshake: a command transfers on a rising edge where cmd_valid & cmd_ready
// are both high. cmd_ready is high only in IDLE. Commands are not queued, so
// the host holds cmd_valid until the transfer. Fields are sampled only on that
// edge.
module combined_counter_ctrl #(
  parameter int WIDTH  = 5,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_mode,
  input  logic              cmd_load,
  input  logic [WIDTH-1:0]  cmd_seed,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              abort,
  output logic [WIDTH-1:0]  d,
  output logic              busy,
  output logic [STEP_W-1:0] steps_left,
  output logic              wrap,
  output logic              done,
  output logic              aborted,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_n;
  logic [WIDTH-1:0]    d_q, d_n;
  logic [WIDTH-1:0]    start_q, start_n;
  logic [STEP_W-1:0]   steps_q, steps_n;
  logic                mode_q, mode_n;
  logic                wrap_q, wrap_n;
  logic                aborted_q, aborted_n;
  logic [WIDTH-1:0]    shifted;
  logic                accept;

  // One shift of the pattern: Johnson feeds back the inverted LSB, ring the LSB.
  function automatic logic [WIDTH-1:0] shift_fn(input logic m, input logic [WIDTH-1:0] v);
    if (m) return {v[0], v[WIDTH-1:1]};
    else   return {~v[0], v[WIDTH-1:1]};
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_n;
  end

  // Next-state and datapath next values; every target gets a default first.
  always_comb begin
    state_n   = state_q;
    d_n       = d_q;
    start_n   = start_q;
    steps_n   = steps_q;
    mode_n    = mode_q;
    wrap_n    = 1'b0;
    aborted_n = 1'b0;
    shifted   = shift_fn(mode_q, d_q);
    accept    = cmd_valid & (state_q == S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mode_n  = cmd_mode;
          steps_n = cmd_steps;
          d_n     = cmd_load ? cmd_seed : d_q;
          start_n = cmd_load ? cmd_seed : d_q;
          state_n = (cmd_steps != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        // Abort takes priority over the shift, including the final one.
        if (abort) begin
          steps_n   = '0;
          aborted_n = 1'b1;
          state_n   = S_DONE;
        end else begin
          d_n     = shifted;
          wrap_n  = (shifted == start_q);
          steps_n = (steps_q != '0) ? steps_q - STEP_W'(1) : '0;
          if (steps_q <= STEP_W'(1)) state_n = S_DONE;
        end
      end
      S_DONE: begin
        // aborted_n defaults to 0, so the flag clears on the way back to IDLE.
        steps_n = '0;
        state_n = S_IDLE;
      end
      default: begin
        steps_n = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  // Datapath registers: pattern, start pattern, step count, mode and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_q       <= '0;
      start_q   <= '0;
      steps_q   <= '0;
      mode_q    <= 1'b0;
      wrap_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      d_q       <= d_n;
      start_q   <= start_n;
      steps_q   <= steps_n;
      mode_q    <= mode_n;
      wrap_q    <= wrap_n;
      aborted_q <= aborted_n;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign d          = d_q;
  assign steps_left = steps_q;
  assign wrap       = wrap_q;
  assign aborted    = aborted_q;
  assign state_dbg  = state_q;

endmodule
